// File: rtl/bcd_seg_scan.sv
// bcd_seg_scan: drives a 2-digit multiplexed 7-segment display from a 5-bit BCD value.
//   The value is captured on a load strobe and the two digits are shown in turn,
//   each for SCAN_DIV clocks. A leading zero can be blanked, and a units digit
//   greater than 9 is shown as a dash and flagged on err.
// Ports:
//   clk    in   1  system clock, rising edge
//   rst_n  in   1  asynchronous active-low reset (release expected synchronous to clk)
//   p      in   5  BCD value; p[4] tens, p[3:0] units
//   ld     in   1  load strobe; p is captured on any edge with ld=1
//   en     in   1  scan enable; 0 blanks the display and freezes the scan
//   seg    out  7  segment drive, gfedcba
//   an     out  2  digit enable; an[0] units, an[1] tens
//   err    out  1  units digit of the last load was greater than 9
module bcd_seg_scan #(
    parameter int unsigned SCAN_DIV       = 50000,
    parameter bit          SEG_ACTIVE_LOW = 1'b1,
    parameter bit          BLANK_LZ       = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] p,
    input  logic       ld,
    input  logic       en,
    output logic [6:0] seg,
    output logic [1:0] an,
    output logic       err
);

    localparam int unsigned CNT_W   = $clog2(SCAN_DIV);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SCAN_DIV - 1);
    localparam logic [6:0]  SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic [1:0]  AN_OFF  = SEG_ACTIVE_LOW ? 2'b11 : 2'b00;
    localparam logic [6:0]  SEG_DASH = 7'b1000000;

    typedef enum logic {
        DIG_UNITS = 1'b0,
        DIG_TENS  = 1'b1
    } digit_e;

    digit_e           idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [4:0]       val_q, val_d;
    logic             err_q, err_d;
    logic [6:0]       seg_q, seg_d;
    logic [1:0]       an_q,  an_d;
    logic             tick_c;
    logic [6:0]       seg_hi_c;
    logic [1:0]       an_hi_c;

    // Active-high gfedcba pattern; anything above 9 renders as a dash.
    function automatic logic [6:0] decode(input logic [3:0] d);
        logic [6:0] s;
        s = SEG_DASH;
        case (d)
            4'd0: s = 7'b0111111;
            4'd1: s = 7'b0000110;
            4'd2: s = 7'b1011011;
            4'd3: s = 7'b1001111;
            4'd4: s = 7'b1100110;
            4'd5: s = 7'b1101101;
            4'd6: s = 7'b1111101;
            4'd7: s = 7'b0000111;
            4'd8: s = 7'b1111111;
            4'd9: s = 7'b1101111;
            default: s = SEG_DASH;
        endcase
        return s;
    endfunction

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q <= DIG_UNITS;
            cnt_q <= '0;
            val_q <= '0;
            err_q <= 1'b0;
            seg_q <= SEG_OFF;
            an_q  <= AN_OFF;
        end else begin
            idx_q <= idx_d;
            cnt_q <= cnt_d;
            val_q <= val_d;
            err_q <= err_d;
            seg_q <= seg_d;
            an_q  <= an_d;
        end
    end

    // Next-state: latch, scan counter/digit select, and display pattern.
    always_comb begin
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        val_d    = val_q;
        err_d    = err_q;
        seg_hi_c = 7'b0000000;
        an_hi_c  = 2'b00;
        tick_c   = (cnt_q == CNT_MAX);

        if (ld) begin
            val_d = p;
            err_d = (p[3:0] > 4'd9);
        end

        if (en) begin
            if (tick_c) begin
                cnt_d = '0;
                idx_d = (idx_q == DIG_UNITS) ? DIG_TENS : DIG_UNITS;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end

        // Output follows the current registered digit; at most one an bit is ever active.
        if (en) begin
            case (idx_q)
                DIG_UNITS: begin
                    an_hi_c  = 2'b01;
                    seg_hi_c = decode(val_q[3:0]);
                end
                DIG_TENS: begin
                    if (!(BLANK_LZ && !val_q[4])) begin
                        an_hi_c  = 2'b10;
                        seg_hi_c = decode({3'b000, val_q[4]});
                    end
                end
                default: begin
                    an_hi_c  = 2'b00;
                    seg_hi_c = 7'b0000000;
                end
            endcase
        end

        seg_d = SEG_ACTIVE_LOW ? ~seg_hi_c : seg_hi_c;
        an_d  = SEG_ACTIVE_LOW ? ~an_hi_c  : an_hi_c;
    end

    assign seg = seg_q;
    assign an  = an_q;
    assign err = err_q;

endmodule

// File: tb/tb_bcd_seg_scan.sv
`timescale 1ns/100ps
module tb_bcd_seg_scan;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] p;
    logic       ld;
    logic       en;
    logic [6:0] seg, seg_nb;
    logic [1:0] an, an_nb;
    logic       err, err_nb;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bcd_seg_scan #(.SCAN_DIV(4), .SEG_ACTIVE_LOW(1'b1), .BLANK_LZ(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .p(p), .ld(ld), .en(en),
        .seg(seg), .an(an), .err(err)
    );

    bcd_seg_scan #(.SCAN_DIV(4), .SEG_ACTIVE_LOW(1'b1), .BLANK_LZ(1'b0)) dut_nb (
        .clk(clk), .rst_n(rst_n), .p(p), .ld(ld), .en(en),
        .seg(seg_nb), .an(an_nb), .err(err_nb)
    );

    // Active-low patterns
    localparam logic [6:0] S_OFF = 7'b1111111;
    localparam logic [6:0] S_0   = 7'b1000000;
    localparam logic [6:0] S_1   = 7'b1111001;
    localparam logic [6:0] S_3   = 7'b0110000;
    localparam logic [6:0] S_5   = 7'b0010010;
    localparam logic [6:0] S_7   = 7'b1111000;
    localparam logic [6:0] S_DSH = 7'b0111111;
    localparam logic [1:0] A_OFF = 2'b11;
    localparam logic [1:0] A_U   = 2'b10;
    localparam logic [1:0] A_T   = 2'b01;

    typedef struct {
        logic       ld;
        logic [4:0] p;
        logic       en;
        logic [6:0] seg;
        logic [1:0] an;
        logic       err;
    } vec_t;

    vec_t tbl[26];

    task automatic chk(input string name, input logic [6:0] act, input logic [6:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // One clock: drive at negedge, sample 1 ns after the following posedge.
    task automatic step(input string name, input logic l, input logic [4:0] pv, input logic e,
                        input logic [6:0] xs, input logic [1:0] xa, input logic xe);
        @(negedge clk);
        ld = l;
        p  = pv;
        en = e;
        @(posedge clk);
        #1;
        chk({name, "_seg"}, seg, xs);
        chk({name, "_an"}, 7'(an), 7'(xa));
        chk({name, "_err"}, 7'(err), 7'(xe));
        chk({name, "_overlap"}, 7'(an == 2'b00), 7'd0);
    endtask

    initial begin
        // Cycle-by-cycle after reset release: idle scan, valid load, invalid load, recovery load.
        for (int i = 0; i < 4; i++)  tbl[i] = '{1'b0, 5'd0, 1'b1, S_0, A_U, 1'b0};
        for (int i = 4; i < 8; i++)  tbl[i] = '{1'b0, 5'd0, 1'b1, S_OFF, A_OFF, 1'b0};
        tbl[8] = '{1'b1, 5'b10101, 1'b1, S_0, A_U, 1'b0};
        for (int i = 9; i < 12; i++) tbl[i] = '{1'b0, 5'd0, 1'b1, S_5, A_U, 1'b0};
        for (int i = 12; i < 16; i++) tbl[i] = '{1'b0, 5'd0, 1'b1, S_1, A_T, 1'b0};
        tbl[16] = '{1'b0, 5'd0, 1'b1, S_5, A_U, 1'b0};
        tbl[17] = '{1'b1, 5'b01100, 1'b1, S_5, A_U, 1'b1};
        tbl[18] = '{1'b0, 5'd0, 1'b1, S_DSH, A_U, 1'b1};
        tbl[19] = '{1'b0, 5'd0, 1'b1, S_DSH, A_U, 1'b1};
        tbl[20] = '{1'b0, 5'd0, 1'b1, S_OFF, A_OFF, 1'b1};
        tbl[21] = '{1'b1, 5'b00111, 1'b1, S_OFF, A_OFF, 1'b0};
        tbl[22] = '{1'b0, 5'd0, 1'b1, S_OFF, A_OFF, 1'b0};
        tbl[23] = '{1'b0, 5'd0, 1'b1, S_OFF, A_OFF, 1'b0};
        tbl[24] = '{1'b0, 5'd0, 1'b1, S_7, A_U, 1'b0};
        tbl[25] = '{1'b0, 5'd0, 1'b1, S_7, A_U, 1'b0};

        rst_n = 1'b0;
        ld    = 1'b0;
        p     = 5'd0;
        en    = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_seg", seg, S_OFF);
        chk("rst_an", 7'(an), 7'(A_OFF));
        chk("rst_err", 7'(err), 7'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 26; i++) begin
            step($sformatf("tbl%0d", i), tbl[i].ld, tbl[i].p, tbl[i].en,
                 tbl[i].seg, tbl[i].an, tbl[i].err);
        end

        // en low for 10 clocks mid-units phase (2 counts left), then resume.
        for (int i = 0; i < 10; i++) step($sformatf("en_off%0d", i), 1'b0, 5'd0, 1'b0, S_OFF, A_OFF, 1'b0);
        step("resume0", 1'b0, 5'd0, 1'b1, S_7, A_U, 1'b0);
        step("resume1", 1'b0, 5'd0, 1'b1, S_7, A_U, 1'b0);
        step("resume2", 1'b0, 5'd0, 1'b1, S_OFF, A_OFF, 1'b0);
        step("resume3", 1'b0, 5'd0, 1'b1, S_OFF, A_OFF, 1'b0);
        step("resume4", 1'b0, 5'd0, 1'b1, S_OFF, A_OFF, 1'b0);
        step("resume5", 1'b0, 5'd0, 1'b1, S_OFF, A_OFF, 1'b0);

        // Load on the same edge as the units->tens tick.
        step("lt0", 1'b0, 5'd0, 1'b1, S_7, A_U, 1'b0);
        step("lt1", 1'b0, 5'd0, 1'b1, S_7, A_U, 1'b0);
        step("lt2", 1'b0, 5'd0, 1'b1, S_7, A_U, 1'b0);
        step("lt_tick", 1'b1, 5'b10101, 1'b1, S_7, A_U, 1'b0);
        step("lt_new", 1'b0, 5'd0, 1'b1, S_1, A_T, 1'b0);
        step("lt5", 1'b0, 5'd0, 1'b1, S_1, A_T, 1'b0);
        step("lt6", 1'b0, 5'd0, 1'b1, S_1, A_T, 1'b0);
        step("lt7", 1'b0, 5'd0, 1'b1, S_1, A_T, 1'b0);
        step("lt8", 1'b0, 5'd0, 1'b1, S_5, A_U, 1'b0);

        // Set err, then a short asynchronous reset pulse mid-phase.
        step("pre_rst0", 1'b1, 5'b01100, 1'b1, S_5, A_U, 1'b1);
        step("pre_rst1", 1'b0, 5'd0, 1'b1, S_DSH, A_U, 1'b1);
        #1;
        rst_n = 1'b0;
        #0.5;
        chk("arst_seg", seg, S_OFF);
        chk("arst_an", 7'(an), 7'(A_OFF));
        chk("arst_err", 7'(err), 7'd0);
        #0.5;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) step($sformatf("post_rst%0d", i), 1'b0, 5'd0, 1'b1, S_0, A_U, 1'b0);
        step("post_rst4", 1'b0, 5'd0, 1'b1, S_OFF, A_OFF, 1'b0);

        // Load 03 during tens phase; the non-blanking instance shows a tens "0".
        step("nb_ld", 1'b1, 5'b00011, 1'b1, S_OFF, A_OFF, 1'b0);
        chk("nb_ld_seg", seg_nb, S_0);
        chk("nb_ld_an", 7'(an_nb), 7'(A_T));
        step("nb_t", 1'b0, 5'd0, 1'b1, S_OFF, A_OFF, 1'b0);
        chk("nb_t_seg", seg_nb, S_0);
        chk("nb_t_an", 7'(an_nb), 7'(A_T));
        chk("nb_t_err", 7'(err_nb), 7'd0);
        step("nb_t2", 1'b0, 5'd0, 1'b1, S_OFF, A_OFF, 1'b0);
        step("nb_u", 1'b0, 5'd0, 1'b1, S_3, A_U, 1'b0);
        chk("nb_u_seg", seg_nb, S_3);
        chk("nb_u_an", 7'(an_nb), 7'(A_U));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bcd_seg_scan.md
Name: bcd_seg_scan

Overview:
- Downstream consumer of the 4-bit binary-to-BCD converter stage.
- Takes the converter's 5-bit BCD result and drives a 2-digit multiplexed 7-segment display.
  - p[4] is the tens digit (0/1); p[3:0] is the units digit.
- Latches the value on a load strobe, time-multiplexes the two digits at a parameterised scan rate, blanks the leading zero, and flags invalid BCD.

Parameters:
- SCAN_DIV, 50000: clock cycles each digit stays enabled; legal range 2..2^20.
- SEG_ACTIVE_LOW, 1: 1 gives active-low seg and an outputs (board default); 0 gives active-high.
- BLANK_LZ, 1: 1 blanks the tens digit when it is 0; 0 always shows it.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- p  in  5  BCD from the converter; p[4] tens, p[3:0] units.
- ld  in  1  load strobe; p is captured on any rising clk edge with ld=1.
- en  in  1  scan enable; 0 blanks the display and freezes the scan.
- seg  out  7  segment drive, bit order gfedcba.
- an  out  2  digit enable; an[0] units, an[1] tens.
- err  out  1  units digit of the last load was greater than 9.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - Latched value = 0, scan counter = 0, digit index = 0 (units).
  - seg = all off, an = both off, err = 0.
  - "Off" means 1 when SEG_ACTIVE_LOW=1, else 0.
  - Deassertion is synchronous to clk.
- Latch:
  - On a clk edge with ld=1, val <= p.
  - err <= (p[3:0] > 9), computed from p, not from the old val.
  - err holds until the next load; ld=0 leaves val and err unchanged.
- Scan counter:
  - Counts 0..SCAN_DIV-1 while en=1.
  - tick = (cnt == SCAN_DIV-1). On tick, cnt wraps to 0 and idx toggles.
  - en=0 holds cnt and idx.
- Output registers:
  - seg and an are registered from (val, idx, en).
  - Latency is 1 clock from any change of val, idx or en to seg/an.
- Units digit (idx=0):
  - an = units-only.
  - seg = decode(val[3:0]) if val[3:0] <= 9, else dash (segment g only).
- Tens digit (idx=1):
  - If BLANK_LZ=1 and val[4]=0: an = both off and seg = all off.
  - Otherwise: an = tens-only and seg = decode({3'b0, val[4]}).
- Decode (active-high gfedcba; inverted when SEG_ACTIVE_LOW=1):
  - 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110
  - 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111
- en=0: next-cycle seg = all off and an = both off. Scanning resumes from the held cnt/idx when en returns to 1.
- Simultaneous ld and tick: both take effect; the next registered output uses the new val and the new idx.
- Never drive both an bits active in the same cycle, including around reset and en edges.
- Reset mid-scan: outputs go off immediately (asynchronous). After release, the first digit shown is units with val=0, i.e. "0", tens blanked when BLANK_LZ=1.

Test Plan (SCAN_DIV=4, SEG_ACTIVE_LOW=1, BLANK_LZ=1 unless noted):
- Reset, then en=1, no load -> seg=1111111 and an=11 during reset.
  - After release: units phase seg=1000000, an=10; tens phase an=11 (blanked).
  - Each phase lasts exactly 4 clocks.
- ld pulse with p=5'b10101 (15) -> err=0.
  - Units phase: seg=0010010 ("5"), an=10.
  - Tens phase: seg=1111001 ("1"), an=01.
  - Alternation every 4 clocks.
- ld with p=5'b01100 (invalid 12) -> err=1 the cycle after the load; units seg=0111111 (dash).
  - A later ld with p=5'b00111 clears err to 0 and shows "7" (seg=1111000), tens blanked.
- en dropped to 0 for 10 clocks mid-phase, then raised -> an=11 and seg=1111111 one clock after the drop.
  - cnt/idx frozen; the same digit resumes with its remaining count.
- ld asserted on the same edge as tick -> next output shows the new value on the new digit.
  - Check for overlap: an never equals 00.
- BLANK_LZ=0, p=5'b00011 -> tens phase seg=1000000 ("0"), an=01.
- rst_n pulsed low for 1 ns mid-phase -> outputs go off immediately and err=0.
  - Units "0" is shown after release.
